// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector with overlap control, input
// qualification and a saturating match counter. Optional SEQ_DET_STICKY_EN adds hit_sticky/hit_clr.
module seq_detector_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               x,
    input  logic               x_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
`ifdef SEQ_DET_STICKY_EN
    ,
    input  logic               hit_clr,
    output logic               hit_sticky
`endif
);

    localparam logic [LEN_W:0] MAX_LEN_W = (LEN_W+1)'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_reg, pat_next;
    logic [MAX_LEN-1:0] hist_reg, hist_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic [LEN_W-1:0]   fill_reg, fill_next;
    logic               ovl_reg, ovl_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               err_reg, err_next;

    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] cand;
    logic               accept;
    logic               fill_ok;
    logic               match;

    // Bit i of the mask is set when bit i of the pattern takes part in the compare.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            localparam int unsigned IDX = gi;
            assign len_mask[gi] = (32'(len_reg) > IDX);
        end
    endgenerate

    assign cand    = {hist_reg[MAX_LEN-2:0], x};
    assign accept  = x_valid && !cfg_load && !err_reg;
    assign fill_ok = ((LEN_W+1)'(fill_reg) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_reg);
    assign match   = accept && fill_ok && (((cand ^ pat_reg) & len_mask) == '0);

    always_comb begin
        pat_next  = pat_reg;
        hist_next = hist_reg;
        len_next  = len_reg;
        fill_next = fill_reg;
        ovl_next  = ovl_reg;
        cnt_next  = cnt_reg;
        err_next  = err_reg;
        if (cfg_load) begin
            pat_next  = cfg_pattern;
            len_next  = cfg_len;
            ovl_next  = cfg_overlap;
            hist_next = '0;
            fill_next = '0;
            cnt_next  = '0;
            err_next  = (cfg_len == '0) || ({1'b0, cfg_len} > MAX_LEN_W);
        end else if (accept) begin
            hist_next = cand;
            if (fill_reg < len_reg) begin
                fill_next = fill_reg + LEN_W'(1);
            end
            if (match) begin
                // Non-overlap mode demands len_reg fresh bits before the next hit.
                if (!ovl_reg) begin
                    fill_next = '0;
                end
                if (cnt_reg != '1) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_reg  <= '0;
            hist_reg <= '0;
            len_reg  <= LEN_W'(1);
            fill_reg <= '0;
            ovl_reg  <= 1'b1;
            cnt_reg  <= '0;
            err_reg  <= 1'b0;
        end else begin
            pat_reg  <= pat_next;
            hist_reg <= hist_next;
            len_reg  <= len_next;
            fill_reg <= fill_next;
            ovl_reg  <= ovl_next;
            cnt_reg  <= cnt_next;
            err_reg  <= err_next;
        end
    end

    assign z         = match;
    assign match_cnt = cnt_reg;
    assign cfg_err   = err_reg;

`ifdef SEQ_DET_STICKY_EN
    logic sticky_reg, sticky_next;

    // A match outranks hit_clr; cfg_load cannot coincide with a match.
    always_comb begin
        sticky_next = sticky_reg;
        if (cfg_load) begin
            sticky_next = 1'b0;
        end else if (match) begin
            sticky_next = 1'b1;
        end else if (hit_clr) begin
            sticky_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_reg <= 1'b0;
        end else begin
            sticky_reg <= sticky_next;
        end
    end

    assign hit_sticky = sticky_reg;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog: the driver pushes reference-model
// expectations per cycle, a monitor pops and compares them mid-cycle.
module tb_seq_detector_prog;

    localparam int MAXL = 8;
    localparam int LW   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            x = 1'b0;
    logic            x_valid = 1'b0;
    logic            cfg_load = 1'b0;
    logic [MAXL-1:0] cfg_pattern = '0;
    logic [LW-1:0]   cfg_len = '0;
    logic            cfg_overlap = 1'b0;
    logic            z;
    logic [CW-1:0]   match_cnt;
    logic            cfg_err;
    logic            hit_clr = 1'b0;
`ifdef SEQ_DET_STICKY_EN
    logic            hit_sticky;
`endif

    seq_detector_prog #(.MAX_LEN(MAXL), .LEN_W(LW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x           (x),
        .x_valid     (x_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .z           (z),
        .match_cnt   (match_cnt),
        .cfg_err     (cfg_err)
`ifdef SEQ_DET_STICKY_EN
        ,
        .hit_clr     (hit_clr),
        .hit_sticky  (hit_sticky)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit z;
        int cnt;
        bit err;
        bit sticky;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;

    // Reference model: the accepted bits since the last restart, as a plain list.
    bit              bits_q[$];
    longint unsigned m_pat;
    int              m_len;
    bit              m_ovl;
    bit              m_err;
    int              m_cnt;
    bit              m_sticky;

    function automatic bit model_match(bit xb);
        bit              tmp[$];
        longint unsigned v;
        longint unsigned mask;
        tmp = bits_q;
        tmp.push_back(xb);
        if (tmp.size() < m_len) return 1'b0;
        v = 0;
        for (int k = tmp.size() - m_len; k < tmp.size(); k++) v = (v << 1) | longint'(tmp[k]);
        mask = (64'd1 << m_len) - 1;
        return v == (m_pat & mask);
    endfunction

    task automatic model_reset();
        bits_q.delete();
        m_pat = 0; m_len = 1; m_ovl = 1'b1; m_err = 1'b0; m_cnt = 0; m_sticky = 1'b0;
    endtask

    task automatic check_val(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock of stimulus: drive, record the expectation, advance the model.
    task automatic step(bit v, bit xb, bit ld, int pat, int len, bit ovl, bit clr);
        exp_t e;
        bit   acc;
        bit   mm;
        x_valid = v; x = xb; cfg_load = ld; hit_clr = clr;
        cfg_pattern = pat[MAXL-1:0]; cfg_len = len[LW-1:0]; cfg_overlap = ovl;
        acc = v && !ld && !m_err;
        mm  = acc && model_match(xb);
        e.idx = txn; e.z = mm; e.cnt = m_cnt; e.err = m_err; e.sticky = m_sticky;
        sb.push_back(e);
        txn++;
        if (ld) begin
            m_err = (len == 0) || (len > MAXL);
            m_pat = longint'(pat[MAXL-1:0]); m_len = len; m_ovl = ovl;
            bits_q.delete(); m_cnt = 0; m_sticky = 1'b0;
        end else if (acc) begin
            bits_q.push_back(xb);
            if (bits_q.size() > MAXL) void'(bits_q.pop_front());
            if (mm) begin
                if (m_cnt < CMAX) m_cnt++;
                if (!m_ovl) bits_q.delete();
                m_sticky = 1'b1;
            end else if (clr) begin
                m_sticky = 1'b0;
            end
        end else if (clr) begin
            m_sticky = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic data(bit v, bit xb);
        step(v, xb, 1'b0, int'($urandom), int'($urandom_range(0, 15)), 1'($urandom), 1'b0);
    endtask

    task automatic load(int pat, int len, bit ovl);
        step(1'b1, 1'($urandom), 1'b1, pat, len, ovl, 1'b0);
    endtask

    task automatic do_reset();
        exp_t e;
        rst_n = 1'b0; x_valid = 1'b0; cfg_load = 1'b0; hit_clr = 1'b0;
        model_reset();
        e.idx = txn; e.z = 1'b0; e.cnt = 0; e.err = 1'b0; e.sticky = 1'b0;
        sb.push_back(e);
        txn++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic feed(int nbits, int val);
        for (int i = nbits - 1; i >= 0; i--) data(1'b1, 1'((val >> i) & 1));
    endtask

    // Monitor: z is combinational, so compare mid-cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                $display("txn %0d: valid=%0b x=%0b load=%0b z=%0b cnt=%0d err=%0b (exp z=%0b cnt=%0d err=%0b)",
                         e.idx, x_valid, x, cfg_load, z, match_cnt, cfg_err, e.z, e.cnt, e.err);
                check_val("z", int'(z), int'(e.z));
                check_val("match_cnt", int'(match_cnt), e.cnt);
                check_val("cfg_err", int'(cfg_err), int'(e.err));
`ifdef SEQ_DET_STICKY_EN
                check_val("hit_sticky", int'(hit_sticky), int'(e.sticky));
`endif
            end
        end
    end

    initial begin
        int r;
        int len;
        int wait_cnt;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // 101 overlapping: hits on bits 3 and 5
        load(32'b101, 3, 1'b1);
        feed(5, 5'b10101);
        check_val("ovl_cnt", int'(match_cnt), 2);

        // 101 non-overlapping: one hit, then a fresh 1,0,1 after 0,1
        load(32'b101, 3, 1'b0);
        feed(5, 5'b10101);
        check_val("novl_cnt1", int'(match_cnt), 1);
        feed(3, 3'b101);
        check_val("novl_cnt2", int'(match_cnt), 2);

        // 8-bit pattern with three invalid cycles between accepted bits
        load(32'hD3, 8, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            data(1'b1, 1'((8'hD3 >> i) & 1));
            for (int g = 0; g < 3; g++) data(1'b0, 1'($urandom));
        end
        check_val("gap_cnt", int'(match_cnt), 1);

        // Mid-stream reload to len=2 pattern 11
        load(32'b101, 3, 1'b1);
        feed(2, 2'b10);
        load(32'b11, 2, 1'b1);
        check_val("reload_cnt0", int'(match_cnt), 0);
        feed(3, 3'b111);
        check_val("reload_cnt", int'(match_cnt), 2);

        // len=1 saturation
        load(32'b1, 1, 1'b1);
        for (int i = 0; i < 20; i++) data(1'b1, 1'b1);
        check_val("sat_cnt", int'(match_cnt), CMAX);

        // Illegal lengths, then a legal reload
        load(32'hFF, 0, 1'b1);
        check_val("err_len0", int'(cfg_err), 1);
        for (int i = 0; i < 6; i++) data(1'b1, 1'($urandom));
        load(32'hFF, 9, 1'b1);
        check_val("err_len9", int'(cfg_err), 1);
        load(32'b1, 1, 1'b1);
        check_val("err_clear", int'(cfg_err), 0);

        // Mid-stream reset discards a partial match
        load(32'b101, 3, 1'b1);
        feed(2, 2'b10);
        do_reset();
        check_val("rst_cnt", int'(match_cnt), 0);

`ifdef SEQ_DET_STICKY_EN
        load(32'b11, 2, 1'b1);
        feed(2, 2'b11);
        check_val("sticky_set", int'(hit_sticky), 1);
        step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
        check_val("sticky_win", int'(hit_sticky), 1);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        check_val("sticky_clr", int'(hit_sticky), 0);
`endif

        // Randomized configurations and streams
        for (int round = 0; round < 8; round++) begin
            r = int'($urandom_range(0, 9));
            len = (r < 7) ? 1 + (r % 4) : ((r == 7) ? 0 : 9);
            if (round == 0) len = 8;
            load(int'($urandom), len, 1'($urandom));
            for (int i = 0; i < 40; i++) begin
                step($urandom_range(0, 3) != 0, 1'($urandom), 1'b0, int'($urandom),
                     int'($urandom_range(0, 15)), 1'($urandom), $urandom_range(0, 7) == 0);
            end
            if (round == 4) do_reset();
        end

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Runtime-programmable serial bit-pattern detector. Generalises the fixed "101" detector to any pattern of 1..MAX_LEN bits.
- Adds overlap / non-overlap mode, input qualification (x_valid), a saturating match counter and config-error flagging.
- Sits on the serial receive path in the same place as the fixed detector; its match pulse z feeds downstream framing/control logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- LEN_W, 4, width of cfg_len; must hold MAX_LEN.
- CNT_W, 8, width of match_cnt.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled only when high.
- cfg_load  in  1  one-cycle strobe; latches the cfg_* inputs and restarts detection.
- cfg_pattern  in  MAX_LEN  pattern. Bit cfg_len-1 is the first bit received; bit 0 is the last.
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = restart after each match.
- z  out  1  match pulse, Mealy: combinational in the cycle the final pattern bit is presented.
- match_cnt  out  CNT_W  number of matches since reset/cfg_load; saturates at all-ones.
- cfg_err  out  1  registered; high while the latched cfg_len is illegal.

Behaviour:
- Registered state:
  - pat_q, len_q, ovl_q: latched configuration.
  - hist[MAX_LEN-1:0]: last accepted bits, newest in bit 0.
  - fill: accepted-bit count since restart, saturating at len_q.
  - match_cnt, cfg_err.
- Reset (async): pat_q=0, len_q=1, ovl_q=1, hist=0, fill=0, match_cnt=0, cfg_err=0. z is therefore 0 unless x_valid=1 and x=0.
- cfg_load=1 (priority over data in the same cycle):
  - Latch pat_q/len_q/ovl_q.
  - Clear hist, fill and match_cnt.
  - cfg_err <= (cfg_len==0 || cfg_len>MAX_LEN).
  - x is ignored in that cycle and z=0.
- Accepted bit: x_valid=1 and cfg_load=0 and cfg_err=0. Non-accepted cycles change no state and force z=0.
- Match: accepted bit and fill >= len_q-1 and {hist[len_q-2:0], x} == pat_q[len_q-1:0]. For len_q=1 the condition is x == pat_q[0].
- On an accepted bit:
  - hist <= {hist[MAX_LEN-2:0], x}.
  - If no match: fill <= min(fill+1, len_q).
  - If match and ovl_q=1: fill <= min(fill+1, len_q).
  - If match and ovl_q=0: fill <= 0, so the next match needs len_q fresh bits.
- z = match (combinational, same cycle as the final bit; zero latency).
- match_cnt increments on each match; holds at 2^CNT_W-1.
- cfg_err=1: detector idle, z=0, match_cnt holds 0 until the next legal cfg_load.
- Reset mid-stream: all state cleared immediately; partial matches are discarded.
- cfg_load mid-stream: same effect as reset except the new config is latched.
- x_valid gaps do not break a partial match; matching operates on accepted bits only.
- Bits of cfg_pattern at or above cfg_len are don't-care.
- Implementation note: the compare uses a per-length mask generated from len_q; no variable part-selects.

Optional Feature:
- Macro: SEQ_DET_STICKY_EN.
- Defined:
  - Adds input hit_clr (1 bit) and output hit_sticky (1 bit, registered, reset 0).
  - hit_sticky is set the cycle after any match and stays high until hit_clr=1 or cfg_load=1.
  - Set wins if a match and hit_clr occur in the same cycle.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- 101, overlap: cfg_pattern=3'b101, cfg_len=3, cfg_overlap=1; accepted bits 1,0,1,0,1 -> z high on bits 3 and 5 only; match_cnt=2.
- 101, non-overlap: same stream with cfg_overlap=0 -> z high on bit 3 only; match_cnt=1. Then bits 0,1 -> no match; further 1,0,1 -> match; match_cnt=2.
- Valid gaps: pattern 8'b11010011, len 8, fed with x_valid low for 3 cycles between each bit -> single z pulse on the last valid bit; z=0 in every invalid cycle.
- Mid-stream reload: after bits 1,0 of pattern 101, pulse cfg_load with len=2, pattern 2'b11 -> match_cnt=0; bits 1,1,1 (overlap) -> z on bits 2 and 3.
- Saturation and len=1: CNT_W=4, pattern 1'b1, len 1; 20 accepted ones -> z every accepted cycle; match_cnt stops at 15.
- Illegal config: cfg_len=0 -> cfg_err=1 next cycle, z=0 for any stream. Legal reload -> cfg_err=0. With SEQ_DET_STICKY_EN: hit_sticky rises one cycle after the first match and clears on hit_clr.
